// File: rtl/nco_seq_ctrl_if.sv
// Command handshake between the pulse/instruction decoder and nco_seq_ctrl.
// The master offers {op, data}; the slave accepts on valid && ready.
interface nco_seq_ctrl_if #(
    parameter int unsigned N = 22
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/nco_seq_ctrl.sv
// Buffers SET_FTW / VZ / RUN / WAIT commands and expands each into the NCO's
// write-enable and mode pattern, keeping z_corr at zero whenever phase free-runs.
module nco_seq_ctrl #(
    parameter int unsigned N            = 22,
    parameter int unsigned Z_CORR_WIDTH = 12,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    nco_seq_ctrl_if.slave           cmd,
    input  logic                    flush,
    output logic                    ftw_wr_en,
    output logic [N-1:0]            ftw_out,
    output logic                    z_corr_wr_en,
    output logic [Z_CORR_WIDTH-1:0] z_corr_out,
    output logic                    phase_wr_en,
    output logic                    z_corr_mode,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] OpSetFtw = 2'd0;
    localparam logic [1:0] OpVz     = 2'd1;
    localparam logic [1:0] OpRun    = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StFtw,
        StVzLoad,
        StVzApply,
        StVzClear,
        StRun,
        StWait
    } state_e;

    state_e               state_q, state_d;
    logic [N-1:0]         data_q, data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [1:0]   op_mem   [FIFO_DEPTH];
    logic [N-1:0] data_mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         empty, full, push, pop;
    logic [1:0]   head_op;
    logic [N-1:0] head_data;

    // Extra pointer bit distinguishes full from empty.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_op   = op_mem[rd_ptr_q[AW-1:0]];
    assign head_data = data_mem[rd_ptr_q[AW-1:0]];

    assign cmd.cmd_ready = rst & ~full;
    assign push          = cmd.cmd_valid & cmd.cmd_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q[AW-1:0]]   <= cmd.cmd_op;
            data_mem[wr_ptr_q[AW-1:0]] <= cmd.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!flush && !empty) begin
                    pop    = 1'b1;
                    data_d = head_data;
                    cnt_d  = head_data[CNT_WIDTH-1:0];
                    unique case (head_op)
                        OpSetFtw: state_d = StFtw;
                        OpVz:     state_d = StVzLoad;
                        OpRun:    state_d = StRun;
                        default:  state_d = StWait;
                    endcase
                end
            end
            StFtw:     state_d = StIdle;
            // A flush mid-VZ still has to clear z_corr before going idle.
            StVzLoad:  state_d = flush ? StVzClear : StVzApply;
            StVzApply: state_d = StVzClear;
            StVzClear: state_d = StIdle;
            StRun, StWait: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_WIDTH'(1);
                if (flush || cnt_q <= CNT_WIDTH'(1)) state_d = StIdle;
            end
            default:   state_d = StIdle;
        endcase
    end

    assign ftw_out = data_q;
    assign busy    = (state_q != StIdle) || !empty;

    always_comb begin
        ftw_wr_en    = 1'b0;
        z_corr_wr_en = 1'b0;
        z_corr_out   = '0;
        phase_wr_en  = 1'b0;
        z_corr_mode  = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            StFtw: begin
                ftw_wr_en = 1'b1;
                done      = 1'b1;
            end
            StVzLoad: begin
                z_corr_wr_en = 1'b1;
                z_corr_out   = data_q[Z_CORR_WIDTH-1:0];
            end
            StVzApply: begin
                z_corr_mode = 1'b1;
                phase_wr_en = 1'b1;
            end
            StVzClear: begin
                z_corr_wr_en = 1'b1;
                done         = 1'b1;
            end
            StRun: begin
                phase_wr_en = (cnt_q != '0);
                done        = (cnt_q <= CNT_WIDTH'(1));
            end
            StWait: done = (cnt_q <= CNT_WIDTH'(1));
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nco_seq_ctrl.sv
// Directed bench for nco_seq_ctrl with a small NCO model driven by its outputs.
module tb_nco_seq_ctrl;

    localparam int unsigned N   = 22;
    localparam int unsigned ZW  = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          ftw_wr_en, z_corr_wr_en, phase_wr_en, z_corr_mode, busy, done;
    logic [N-1:0]  ftw_out;
    logic [ZW-1:0] z_corr_out;

    nco_seq_ctrl_if #(.N(N)) cif ();

    nco_seq_ctrl #(
        .N            (N),
        .Z_CORR_WIDTH (ZW),
        .CNT_WIDTH    (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cif),
        .flush        (flush),
        .ftw_wr_en    (ftw_wr_en),
        .ftw_out      (ftw_out),
        .z_corr_wr_en (z_corr_wr_en),
        .z_corr_out   (z_corr_out),
        .phase_wr_en  (phase_wr_en),
        .z_corr_mode  (z_corr_mode),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // NCO model: z_corr_mode advances by z_corr only, otherwise ftw + z_corr.
    logic [N-1:0]  ph_m, ftw_m;
    logic [ZW-1:0] zc_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_m  <= '0;
            ftw_m <= '0;
            zc_m  <= '0;
        end else begin
            if (ftw_wr_en)    ftw_m <= ftw_out;
            if (z_corr_wr_en) zc_m  <= z_corr_out;
            if (phase_wr_en)  ph_m  <= z_corr_mode ? ph_m + N'(zc_m) : ph_m + ftw_m + N'(zc_m);
        end
    end

    int           ph_cnt = 0;
    logic [N-1:0] ftw_log [$];
    always @(posedge clk) begin
        if (phase_wr_en) ph_cnt <= ph_cnt + 1;
        if (ftw_wr_en)   ftw_log.push_back(ftw_out);
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           snap_ph, snap_log, n;
        logic [6:0]   exp_ph, exp_done;
        logic [N-1:0] v;

        rst = 1'b0; flush = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_op = 2'd0; cif.cmd_data = '0;
        #3;
        check("rst_ready", cif.cmd_ready, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_ftw",   ftw_out, 0);
        check("rst_phase", phase_wr_en, 0);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("post_rst_ready", cif.cmd_ready, 1);

        // SET_FTW: output appears two edges after acceptance.
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'd0; cif.cmd_data = 22'h012345;
        tick();
        cif.cmd_valid = 1'b0;
        check("ftw_lat0_en", ftw_wr_en, 0);
        check("ftw_lat0_busy", busy, 1);
        tick();
        check("ftw_en",   ftw_wr_en, 1);
        check("ftw_val",  ftw_out, 22'h012345);
        check("ftw_done", done, 1);
        tick();
        check("ftw_en_off", ftw_wr_en, 0);
        check("ftw_idle_busy", busy, 0);

        // VZ 0x0A5: load, apply, clear.
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'd1; cif.cmd_data = 22'h0000A5;
        tick();
        cif.cmd_valid = 1'b0;
        tick();
        check("vz_load_en",  z_corr_wr_en, 1);
        check("vz_load_val", z_corr_out, 12'h0A5);
        check("vz_load_ph",  phase_wr_en, 0);
        tick();
        check("vz_apply_mode", z_corr_mode, 1);
        check("vz_apply_ph",   phase_wr_en, 1);
        check("vz_apply_zwe",  z_corr_wr_en, 0);
        tick();
        check("vz_clear_en",   z_corr_wr_en, 1);
        check("vz_clear_val",  z_corr_out, 0);
        check("vz_clear_done", done, 1);
        check("vz_phase_model", ph_m, 22'h0000A5);
        tick();
        check("vz_zc_model", zc_m, 0);

        // RUN 0, RUN 3, WAIT 2 back to back.
        snap_ph = ph_cnt;
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'd2; cif.cmd_data = 22'd0;
        tick();
        cif.cmd_data = 22'd3;
        tick();
        check("run0_ph",   phase_wr_en, 0);
        check("run0_done", done, 1);
        cif.cmd_op = 2'd3; cif.cmd_data = 22'd2;
        tick();
        cif.cmd_valid = 1'b0;
        exp_ph   = 7'b0001110;
        exp_done = 7'b1001000;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("seq_ph_%0d", i), phase_wr_en, exp_ph[i]);
            check($sformatf("seq_done_%0d", i), done, exp_done[i]);
            tick();
        end
        check("seq_busy", busy, 0);
        check("seq_ph_total", ph_cnt - snap_ph, 3);
        check("seq_phase_model", ph_m, 22'h036A74);

        // Fill the FIFO while RUN 100 stalls the FSM.
        snap_ph = ph_cnt;
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'd2; cif.cmd_data = 22'd100;
        tick();
        cif.cmd_valid = 1'b0;
        tick();
        snap_log = ftw_log.size();
        for (int i = 0; i < 4; i++) begin
            cif.cmd_valid = 1'b1; cif.cmd_op = 2'd0; cif.cmd_data = N'(22'h111 * (i + 1));
            tick();
        end
        cif.cmd_data = 22'h000555;
        check("full_ready", cif.cmd_ready, 0);
        tick(); tick(); tick();
        check("full_held_ready", cif.cmd_ready, 0);
        check("full_no_ftw", ftw_log.size() - snap_log, 0);
        n = 0;
        while (!cif.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("full_wait", n < 200, 1);
        tick();
        cif.cmd_valid = 1'b0;
        repeat (40) tick();
        check("full_run_ph", ph_cnt - snap_ph, 100);
        check("full_count", ftw_log.size() - snap_log, 5);
        for (int i = 0; i < 5; i++) begin
            v = N'(22'h111 * (i + 1));
            if (snap_log + i < ftw_log.size())
                check($sformatf("full_order_%0d", i), ftw_log[snap_log + i], v);
        end

        // Flush during VZ_LOAD with two commands queued behind it.
        snap_ph  = ph_cnt;
        snap_log = ftw_log.size();
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'd3; cif.cmd_data = 22'd3;
        tick();
        cif.cmd_op = 2'd1; cif.cmd_data = 22'h00003C;
        tick();
        cif.cmd_op = 2'd0; cif.cmd_data = 22'h0ABCDE;
        tick();
        cif.cmd_op = 2'd2; cif.cmd_data = 22'd5;
        tick();
        cif.cmd_valid = 1'b0;
        tick(); tick();
        check("fl_load_en",  z_corr_wr_en, 1);
        check("fl_load_val", z_corr_out, 12'h03C);
        flush = 1'b1;
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'd0; cif.cmd_data = 22'h077777;
        check("fl_ready", cif.cmd_ready, 1);
        tick();
        flush = 1'b0; cif.cmd_valid = 1'b0;
        check("fl_clear_en",   z_corr_wr_en, 1);
        check("fl_clear_val",  z_corr_out, 0);
        check("fl_clear_mode", z_corr_mode, 0);
        check("fl_clear_ph",   phase_wr_en, 0);
        tick();
        check("fl_busy", busy, 0);
        repeat (8) tick();
        check("fl_no_exec", ftw_log.size() - snap_log, 0);
        check("fl_no_phase", ph_cnt - snap_ph, 0);
        check("fl_busy_late", busy, 0);
        check("fl_zc_model", zc_m, 0);

        // Asynchronous reset in the middle of RUN 10 with an FTW queued.
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'd2; cif.cmd_data = 22'd10;
        tick();
        cif.cmd_op = 2'd0; cif.cmd_data = 22'h099999;
        tick();
        cif.cmd_valid = 1'b0;
        tick(); tick();
        check("rr_running", phase_wr_en, 1);
        rst = 1'b0;
        #1;
        check("rr_ph",    phase_wr_en, 0);
        check("rr_busy",  busy, 0);
        check("rr_ready", cif.cmd_ready, 0);
        check("rr_done",  done, 0);
        check("rr_ftw",   ftw_out, 0);
        tick();
        rst = 1'b1;
        #1;
        check("rr_ready_rel", cif.cmd_ready, 1);
        check("rr_busy_rel", busy, 0);
        snap_log = ftw_log.size();
        snap_ph  = ph_cnt;
        repeat (6) tick();
        check("rr_no_stale", ftw_log.size() - snap_log, 0);
        check("rr_no_phase", ph_cnt - snap_ph, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_seq_ctrl.md
# nco_seq_ctrl

Command sequencer for one N-bit NCO: it buffers a stream of frequency, virtual-Z and run/wait commands and turns each into the exact write-enable and mode pattern the NCO needs. It sits between the pulse/instruction decoder and the NCO, driving the NCO's ftw, z_corr, phase_wr_en and z_corr_mode inputs. It guarantees that the NCO's z_corr register is zero whenever the phase is free-running.

## Interface
Parameters:
- N, 22, NCO phase/FTW width; cmd_data width
- Z_CORR_WIDTH, 12, NCO z-correction width (≤ N)
- CNT_WIDTH, 16, run/wait cycle-count width (≤ N)
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥ 2)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full, forced 0 while rst low
- cmd_op  in  2  0=SET_FTW, 1=VZ, 2=RUN, 3=WAIT
- cmd_data  in  N  payload (FTW, Z angle in low Z_CORR_WIDTH bits, or count in low CNT_WIDTH bits)
- flush  in  1  synchronous abort: drop queued commands, end current one safely
- ftw_wr_en  out  1  to NCO
- ftw_out  out  N  to NCO ftw_in
- z_corr_wr_en  out  1  to NCO
- z_corr_out  out  Z_CORR_WIDTH  to NCO z_corr_in
- phase_wr_en  out  1  to NCO
- z_corr_mode  out  1  to NCO
- busy  out  1  state != IDLE or FIFO non-empty
- done  out  1  one-cycle pulse in final cycle of each command

## Operation
- Command is accepted on a rising edge where cmd_valid && cmd_ready. {op,data} is written into the FIFO. FIFO order is preserved.
- FSM states: IDLE, FTW, VZ_LOAD, VZ_APPLY, VZ_CLEAR, RUN, WAIT.
- IDLE: all NCO outputs 0. If the FIFO is non-empty, pop the head, latch the payload into data_q and the count into cnt_q, and go to the op state.
- FTW (1 cycle): ftw_wr_en=1, ftw_out=data_q, done=1, then IDLE.
- VZ_LOAD (1 cycle): z_corr_wr_en=1, z_corr_out=data_q[Z_CORR_WIDTH-1:0].
- VZ_APPLY (1 cycle): z_corr_mode=1, phase_wr_en=1, so the NCO phase advances by z_corr only.
- VZ_CLEAR (1 cycle): z_corr_wr_en=1, z_corr_out=0, done=1, then IDLE.
- RUN: phase_wr_en=1 for exactly cnt_q cycles, with cnt_q decrementing each cycle; done is asserted in the last of those cycles. If cnt=0: one cycle with phase_wr_en=0 and done=1.
- WAIT: identical to RUN but phase_wr_en=0 throughout (phase frozen).
- Outputs are Moore-decoded from registered state, data_q and cnt_q only. No combinational path from cmd_* or flush to the NCO outputs.
- ftw_out shows data_q at all times; z_corr_out is 0 outside VZ_LOAD.
- flush, sampled on a rising edge:
  - FIFO is emptied.
  - From FTW, RUN, WAIT or IDLE: next state is IDLE, with no done pulse.
  - From VZ_LOAD or VZ_APPLY: next state is VZ_CLEAR (skipping APPLY if in LOAD), so z_corr is always cleared.
  - A push in the same cycle as flush is discarded, and cmd_ready stays 1.
- FIFO full: cmd_ready=0 and the push is ignored. A pop while full raises cmd_ready the next cycle. There is no same-cycle pass-through.
- Reset (rst low, any time): FIFO empty, state IDLE, data_q=0, cnt_q=0, and all outputs 0, including cmd_ready, busy and done.
  - The NCO's z_corr is not cleared by this block; the system resets the NCO together with this controller.

## Timing
- Handshake edge E0 → FIFO non-empty after E0 → pop at E1 → first output cycle is the cycle after E1 (2-cycle latency from acceptance).
- Back-to-back commands have one IDLE bubble between them.
- Cycles per command:
  - SET_FTW: 1 (+1 IDLE)
  - VZ: 3 (+1 IDLE)
  - RUN/WAIT count k: max(k,1) (+1 IDLE)
- phase_wr_en is high for exactly k consecutive cycles per RUN k, and for exactly 1 cycle per VZ.
- done aligns with the last active output cycle of each command.

## Test plan
- Reset then push SET_FTW 0x012345: ftw_wr_en high exactly 1 cycle with ftw_out=0x012345, 2 cycles after acceptance; done in the same cycle.
- VZ 0x0A5: z_corr_wr_en/0x0A5, then z_corr_mode=phase_wr_en=1, then z_corr_wr_en/0x000. NCO-model phase increases by 0x0A5<<0 only; the next RUN adds FTW only.
- Push 5 commands with FIFO_DEPTH=4 while the FSM is stalled in RUN 100: cmd_ready drops after the 4th, the 5th is held, and all execute in order.
- RUN 0, then RUN 3, then WAIT 2: done at cycles 1, 3 and 2 of each; phase_wr_en high exactly 3 cycles total.
- flush during VZ_LOAD with 2 queued commands: next state VZ_CLEAR (z_corr_out=0), then IDLE; queued commands never execute; busy=0 afterwards.
- rst low mid-RUN for 1 cycle: all outputs 0 immediately (asynchronous); after release, cmd_ready=1, FIFO empty, no stale command executes.
